// File: rtl/bidirect_cnt_8_pkg.sv
// Shared sizing constants for the up/down counter and any sibling blocks
// that need to size their buses to match it.
package bidirect_cnt_8_pkg;

    localparam int                   CNT_WIDTH     = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_RESET_VAL = '0;

endpackage

// File: rtl/bidirect_cnt_8.sv
// Synchronous up/down counter with parallel load and count enable.
// Priority on each edge: reset, then load, then count, otherwise hold.
module bidirect_cnt_8
    import bidirect_cnt_8_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] STEP    = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RESET_VAL);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // d is only consulted under load, so an unknown d cannot leak into q otherwise.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            if (up_down) begin
                q_d = q_q + STEP;
            end else begin
                q_d = q_q - STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_bidirect_cnt_8.sv
// Directed and randomized checks of bidirect_cnt_8 against an arithmetic
// reference model of the counter rules.
module tb_bidirect_cnt_8;

    logic       clk = 1'b0;
    logic       reset, en, load, up_down;
    logic [7:0] d;
    logic [7:0] q;

    int checks = 0;
    int errors = 0;
    int mdl;

    logic [7:0] up_seq [4];
    logic [7:0] dn_seq [4];

    always #5 clk = ~clk;

    bidirect_cnt_8 #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .up_down (up_down),
        .d       (d),
        .q       (q)
    );

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (q === exp) else begin
            errors++;
            $error("FAIL %s: q=%h expected %h", tag, q, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e,
                         input logic u, input logic [7:0] dv);
        reset   = r;
        load    = l;
        en      = e;
        up_down = u;
        d       = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        up_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        dn_seq = '{8'h01, 8'h00, 8'hFF, 8'hFE};

        // Reset dominates load and en
        drive(1, 1, 1, 1, 8'hA5);
        tick();
        tick();
        chk("reset", 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        repeat (3) tick();
        chk("reset_hold", 8'h00);

        // Count up through wrap
        drive(0, 1, 0, 0, 8'hFD);
        tick();
        chk("load_FD", 8'hFD);
        drive(0, 0, 1, 1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("count_up", up_seq[i]);
        end

        // Count down through wrap
        drive(0, 1, 0, 0, 8'h02);
        tick();
        chk("load_02", 8'h02);
        drive(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("count_down", dn_seq[i]);
        end

        // Load beats count, then counting continues from loaded value
        drive(0, 1, 1, 1, 8'h3C);
        tick();
        chk("load_prio", 8'h3C);
        load = 1'b0;
        tick();
        chk("after_load", 8'h3D);

        drive(0, 0, 0, 1, 8'h55);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_hold", 8'h3D);
        end

        drive(0, 1, 0, 0, 8'hC3);
        tick();
        chk("load_no_en", 8'hC3);

        // Unknown d without load must not disturb q
        drive(0, 0, 0, 0, 8'h00);
        d = 'x;
        tick();
        chk("x_d_hold", 8'hC3);
        en      = 1'b1;
        up_down = 1'b1;
        tick();
        chk("x_d_count", 8'hC4);

        // Reset pulse between edges is not sampled
        drive(0, 0, 0, 0, 8'h00);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        chk("reset_glitch", 8'hC4);

        // Reset mid-count overrides load
        drive(0, 1, 0, 0, 8'h0F);
        tick();
        drive(0, 0, 1, 1, 8'h00);
        tick();
        chk("count_to_10", 8'h10);
        drive(1, 1, 1, 1, 8'h77);
        tick();
        chk("reset_mid", 8'h00);
        drive(0, 0, 1, 1, 8'h00);
        tick();
        chk("resume", 8'h01);

        // Randomized run against arithmetic model
        mdl = 1;
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 1'($urandom), 8'($urandom));
            if (reset)
                mdl = 0;
            else if (load)
                mdl = int'(d);
            else if (en)
                mdl = up_down ? (mdl + 1) % 256 : (mdl + 255) % 256;
            tick();
            chk("random", 8'(mdl));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bidirect_cnt_8.md
Name: bidirect_cnt_8

Overview:
- Synchronous 8-bit up/down counter with parallel load and count enable.
- General-purpose counting primitive for datapath/control logic: address stepping, event counting, timers.
- Single clock domain; all state updates on the rising edge of clk.

Parameters:
- WIDTH, 8, counter and load-data width in bits. The module is verified at 8 only; other values are legal but not required to be tested.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; clears q
- en  input  1  count enable; 1 = count on this edge
- load  input  1  parallel load strobe; 1 = q takes d on this edge
- up_down  input  1  direction; 1 = increment, 0 = decrement
- d  input  WIDTH  parallel load value
- q  output  WIDTH  registered counter value

Behaviour:
- q is a register. It updates only on the rising edge of clk and has no combinational path from any input.
- Per-edge priority, highest first:
  - reset=1: q <= 0.
  - else load=1: q <= d. en and up_down are ignored; load does not require en.
  - else en=1 and up_down=1: q <= q + 1, modulo 2^WIDTH.
  - else en=1 and up_down=0: q <= q - 1, modulo 2^WIDTH.
  - else: q holds.
- Reset value of q is 0x00.
- Reset is synchronous. Asserting reset between edges has no effect until the next rising edge.
- Reset asserted mid-count overrides load and en on that edge. Counting resumes from 0x00 on the first edge after reset deasserts.
- Before the first reset edge, q is undefined (X in simulation). No initial value is relied upon.
- Wrap-around:
  - Up from 0xFF gives 0x00.
  - Down from 0x00 gives 0xFF.
  - No carry or borrow output; wrap is silent.
- Latency:
  - A load or count is visible on q one clock after the sampling edge.
  - A load followed by en=1 on the next edge counts from the loaded value.
- Changing up_down takes effect on the next enabled edge. No turnaround cycle.
- Inputs are sampled only at the clock edge. X on d while load=0 must not corrupt q.

Decomposition:
- Shared package holds CNT_WIDTH = 8 and CNT_RESET_VAL = '0, so sibling blocks size buses consistently.
- No typedefs are required.
- No sub-module: a single always_ff block plus a next-state expression is the whole design.
- If the next-state logic is factored out, name it cnt_next (a pure combinational function or module: q, d, load, en, up_down -> next q).

Test Plan:
- Reset: drive reset=1 for 2 edges with en=1, load=1, d=0xA5 -> q=0x00; hold all inputs 0 for 3 edges -> q remains 0x00.
- Count up and wrap: after reset, load d=0xFD, then en=1, up_down=1 for 4 edges -> q sequence 0xFD, 0xFE, 0xFF, 0x00, 0x01.
- Count down and wrap: load d=0x02, then en=1, up_down=0 for 4 edges -> q sequence 0x02, 0x01, 0x00, 0xFF, 0xFE.
- Load priority and enable gating:
  - With en=1 and up_down=1, pulse load=1 with d=0x3C -> q=0x3C (not 0x3D); next edge -> 0x3D.
  - en=0 with load=0 for 5 edges -> q holds.
  - Load with en=0 -> q takes d.
- Reset priority mid-operation:
  - While counting up at q=0x10, assert reset together with load=1, d=0x77 -> q=0x00 on that edge.
  - Deassert reset with en=1, up_down=1 -> q=0x01 on the next edge.
- Randomised check: 1000 cycles of random reset (rare), load, en, up_down, d against a reference model -> q matches every cycle.
